// File: rtl/sha3_burst_ctrl.sv
// Burst read controller feeding the SHA3 input FIFO: splits a job into bus bursts.
// Define SHA3_BURST_4K_SPLIT_EN to keep every burst inside one 4 KB address page.

module sha3_burst_ctrl #(
   parameter int  BURST_BEATS = 8,
   parameter int  FIFO_DEPTH  = 32,
   localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [31:0]    src_addr,
   input  logic [15:0]    num_beats,
   output logic           busy,
   output logic           done,
   output logic           err,
   output logic           bus_req,
   output logic [31:0]    bus_addr,
   output logic [7:0]     bus_len,
   input  logic           bus_gnt,
   input  logic           rd_valid,
   input  logic [127:0]   rd_data,
   input  logic           rd_last,
   output logic           fifo_wr_en,
   output logic [127:0]   fifo_wr_data,
   input  logic [CW-1:0]  fifo_count
);

   typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

   localparam logic [15:0] MAX_BEATS = 16'(BURST_BEATS);

   state_t        state, state_nxt;
   logic [31:0]   addr, ld_addr;
   logic [15:0]   remaining, ld_rem;
   logic [4:0]    len, len_nxt, beat_cnt;
   logic          armed;
   logic          start_ok, beat_fire, last_beat, final_beat, enter_req;
   logic          space_ok, frame_err, stray_beat;
`ifdef SHA3_BURST_4K_SPLIT_EN
   logic [8:0]    page_cap;
`endif

   assign start_ok   = (state == IDLE) && start;
   assign beat_fire  = (state == DATA) && rd_valid;
   assign last_beat  = (beat_cnt + 5'd1) == len;
   assign final_beat = beat_fire && last_beat;
   assign enter_req  = (state_nxt == REQ) && (state != REQ);
   assign space_ok   = (32'(fifo_count) + 32'({len, 1'b0})) <= 32'(FIFO_DEPTH);
   assign frame_err  = beat_fire && (rd_last != last_beat);
   // armed stays low after reset so beats from an abandoned burst are dropped silently
   assign stray_beat = rd_valid && (state != DATA) && armed;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (num_beats == 16'd0) ? DONE : REQ;
         REQ:     if (bus_req && bus_gnt) state_nxt = DATA;
         DATA:    if (final_beat) state_nxt = (remaining == {11'd0, len}) ? DONE : REQ;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == REQ) || (state == DATA);
      done = (state == DONE);
   end

   // Address/remaining as they will be on entry to REQ, and the burst length derived from them
   always_comb begin
      ld_addr = (state == IDLE) ? src_addr  : addr + {23'd0, len, 4'd0};
      ld_rem  = (state == IDLE) ? num_beats : remaining - {11'd0, len};
      len_nxt = (ld_rem > MAX_BEATS) ? MAX_BEATS[4:0] : ld_rem[4:0];
`ifdef SHA3_BURST_4K_SPLIT_EN
      page_cap = 9'((13'd4096 - {1'b0, ld_addr[11:0]}) >> 4);
      if ({4'd0, len_nxt} > page_cap) len_nxt = page_cap[4:0];
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr         <= '0;
         remaining    <= '0;
         len          <= '0;
         beat_cnt     <= '0;
         armed        <= 1'b0;
         err          <= 1'b0;
         bus_req      <= 1'b0;
         bus_addr     <= '0;
         bus_len      <= '0;
         fifo_wr_en   <= 1'b0;
         fifo_wr_data <= '0;
      end else begin
         fifo_wr_en <= beat_fire;
         if (beat_fire) fifo_wr_data <= rd_data;

         if (start_ok && num_beats != 16'd0) begin
            addr      <= src_addr;
            remaining <= num_beats;
         end else if (final_beat) begin
            addr      <= ld_addr;
            remaining <= ld_rem;
         end

         if (enter_req) begin
            len      <= len_nxt;
            bus_addr <= ld_addr;
            bus_len  <= 8'(len_nxt) - 8'd1;
            beat_cnt <= '0;
         end else if (beat_fire) begin
            beat_cnt <= beat_cnt + 5'd1;
         end

         // Once raised, the request is held until the grant
         if (state == REQ) begin
            if (!bus_req)     bus_req <= space_ok;
            else if (bus_gnt) bus_req <= 1'b0;
         end else begin
            bus_req <= 1'b0;
         end

         if (start_ok) begin
            err   <= 1'b0;
            armed <= 1'b1;
         end else if (frame_err || stray_beat) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: doc/sha3_burst_ctrl.md
SHA3_BURST_CTRL -- requirements
Module: sha3_burst_ctrl

Interface
REQ-001 Parameter BURST_BEATS, default 8, max 128-bit beats per bus burst (1..16).
REQ-002 Parameter FIFO_DEPTH, default 32, downstream FIFO capacity in 64-bit words.
REQ-003 Port clk  in  1  single clock; all logic on posedge clk.
REQ-004 Port rst  in  1  reset, synchronous, active-high.
REQ-005 Port start  in  1  single-cycle job launch pulse.
REQ-006 Port src_addr  in  32  job base byte address; bits [3:0] are zero (16-byte aligned).
REQ-007 Port num_beats  in  16  job length in 128-bit beats.
REQ-008 Port busy  out  1  high from the cycle after an accepted start until done.
REQ-009 Port done  out  1  one-cycle completion pulse.
REQ-010 Port err  out  1  sticky burst-framing error flag.
REQ-011 Port bus_req  out  1  burst read request valid.
REQ-012 Port bus_addr  out  32  burst start byte address.
REQ-013 Port bus_len  out  8  burst length minus one, in beats.
REQ-014 Port bus_gnt  in  1  request accepted when bus_req && bus_gnt.
REQ-015 Port rd_valid  in  1  read data beat valid.
REQ-016 Port rd_data  in  128  read data beat.
REQ-017 Port rd_last  in  1  bus marks final beat of the burst.
REQ-018 Port fifo_wr_en  out  1  write strobe to the 128-in/64-out FIFO (adds 2 words).
REQ-019 Port fifo_wr_data  out  128  FIFO write data.
REQ-020 Port fifo_count  in  $clog2(FIFO_DEPTH)+1  FIFO occupancy in 64-bit words.

Function
REQ-021 FSM states IDLE, REQ, DATA, DONE; at most one burst outstanding.
REQ-022 IDLE: start with num_beats!=0 latches addr=src_addr and remaining=num_beats, then moves to REQ; start with num_beats==0 moves directly to DONE.
REQ-023 start is ignored in every state except IDLE.
REQ-024 Burst length len = min(remaining, BURST_BEATS), computed at entry to REQ.
REQ-025 REQ: bus_req asserts only when FIFO_DEPTH - fifo_count >= 2*len; it then holds bus_addr and bus_len stable until the grant, and moves to DATA on bus_req && bus_gnt.
REQ-026 DATA: each rd_valid beat is registered, so fifo_wr_en=1 and fifo_wr_data=rd_data appear exactly 1 cycle later; the beat counter increments.
REQ-027 The burst ends when the beat counter reaches len: remaining -= len, addr += len*16.
REQ-028 At burst end, remaining==0 moves to DONE; otherwise the FSM moves to REQ.
REQ-029 err is set when rd_last arrives before the final beat, or is absent on the final beat; the beat count alone still governs termination.
REQ-030 rd_valid outside DATA is dropped: no FIFO write, err set.
REQ-031 DONE: done=1 for exactly one cycle, busy=0, then the FSM returns to IDLE.
REQ-032 err clears only on reset or on an accepted start.
REQ-033 addr arithmetic is 32-bit modulo, with wrap past 0xFFFFFFF0 to 0.

Reset
REQ-034 rst has priority over all inputs; state=IDLE, busy=0, done=0, err=0, bus_req=0, bus_addr=0, bus_len=0, fifo_wr_en=0, fifo_wr_data=0, counters=0.
REQ-035 rst mid-burst abandons the job; beats arriving after reset are dropped without setting err.

Configuration
REQ-036 Macro SHA3_BURST_4K_SPLIT_EN defined: len is additionally capped so that no burst crosses a 4 KB address boundary, i.e. len <= (4096 - addr[11:0])/16.
REQ-037 Macro SHA3_BURST_4K_SPLIT_EN undefined: len = min(remaining, BURST_BEATS) only, with no boundary check.

Verification
REQ-038 Defaults, src_addr=0x1000, num_beats=20, fifo_count=0, bus_gnt=1 -> bursts (0x1000,len7),(0x1080,len7),(0x1100,len3); 20 fifo_wr_en pulses; then 1 done pulse.
REQ-039 fifo_count=20 during REQ with len=8 -> bus_req stays 0; when fifo_count drops to 16, bus_req=1 on the next cycle.
REQ-040 start with num_beats=0 -> done pulses 1 cycle later; bus_req never asserts.
REQ-041 rd_last on beat 3 of an 8-beat burst -> err=1; all 8 beats are still written; err stays 1 until the next start.
REQ-042 With SHA3_BURST_4K_SPLIT_EN, src_addr=0x0FE0 and num_beats=8 -> bursts (0x0FE0,len1),(0x1000,len5); without the macro -> a single burst (0x0FE0,len7).
REQ-043 rst asserted on the 4th beat of a burst -> the next cycle shows all outputs at reset values; later rd_valid beats cause no fifo_wr_en and err=0.
